// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the two-port shift arbiter: shifter op codes and default widths.
package shift_arbiter_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_SHAMT_W = 5;

  localparam logic [1:0] SH_SLL  = 2'b00;
  localparam logic [1:0] SH_SRL  = 2'b01;
  localparam logic [1:0] SH_PASS = 2'b10;
  localparam logic [1:0] SH_SRA  = 2'b11;

  // Port index of a one-hot two-bit grant (bit 1 set means port 1).
  function automatic logic grant_port(input logic [1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Bundle of requester, response and shared-shifter signals around shift_arbiter.
interface shift_arbiter_if
  import shift_arbiter_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SHAMT_W = DEF_SHAMT_W
);
  logic               req0_valid, req1_valid;
  logic               req0_ready, req1_ready;
  logic [1:0]         req0_fun, req1_fun;
  logic [SHAMT_W-1:0] req0_shamt, req1_shamt;
  logic [DATA_W-1:0]  req0_data, req1_data;
  logic               resp0_valid, resp1_valid;
  logic               resp0_ready, resp1_ready;
  logic [DATA_W-1:0]  resp0_data, resp1_data;
  logic [DATA_W-1:0]  sh_a, sh_b;
  logic [1:0]         sh_fun;
  logic [DATA_W-1:0]  sh_out;

  // Arbiter side.
  modport slave (
    input  req0_valid, req1_valid, req0_fun, req1_fun, req0_shamt, req1_shamt,
    input  req0_data, req1_data, resp0_ready, resp1_ready, sh_out,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_data, resp1_data,
    output sh_a, sh_b, sh_fun
  );

  // Requester / shifter side.
  modport master (
    output req0_valid, req1_valid, req0_fun, req1_fun, req0_shamt, req1_shamt,
    output req0_data, req1_data, resp0_ready, resp1_ready, sh_out,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_data, resp1_data,
    input  sh_a, sh_b, sh_fun
  );
endinterface

// File: rtl/shift_arb_rr.sv
// Two-way grant selection: a lone eligible port wins, on contention the port other than last.
module shift_arb_rr (
  input  logic [1:0] elig,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = elig;
    if (elig == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port arbiter in front of an external shared shifter, one result register per port.
// Define SHIFT_ARB_FIXED_PRIO_EN to make port 0 always win contention instead of round-robin.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input logic           clk,
  input logic           reset,
  shift_arbiter_if.slave bus
);

  logic [1:0]        elig;
  logic [1:0]        grant_rr;
  logic [1:0]        grant;
  logic              last;
  logic [1:0]        vld_p1;
  logic [DATA_W-1:0] data_p1 [2];

  // A slot is free if empty or being drained this same cycle.
  assign elig[0] = bus.req0_valid && (!vld_p1[0] || bus.resp0_ready);
  assign elig[1] = bus.req1_valid && (!vld_p1[1] || bus.resp1_ready);

  shift_arb_rr u_rr (
    .elig  (elig),
    .last  (last),
    .grant (grant_rr)
  );

  assign grant          = reset ? 2'b00 : grant_rr;
  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  always_comb begin
    bus.sh_a   = '0;
    bus.sh_b   = '0;
    bus.sh_fun = 2'b00;
    if (grant[0]) begin
      bus.sh_a   = DATA_W'(bus.req0_shamt);
      bus.sh_b   = bus.req0_data;
      bus.sh_fun = bus.req0_fun;
    end else if (grant[1]) begin
      bus.sh_a   = DATA_W'(bus.req1_shamt);
      bus.sh_b   = bus.req1_data;
      bus.sh_fun = bus.req1_fun;
    end
  end

`ifdef SHIFT_ARB_FIXED_PRIO_EN
  assign last = 1'b1;
`else
  always_ff @(posedge clk) begin
    if (reset)      last <= 1'b1;
    else if (|grant) last <= grant_port(grant);
  end
`endif

  // ---- p1: result registers, written one cycle after grant ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1     <= 2'b00;
      data_p1[0] <= '0;
      data_p1[1] <= '0;
    end else begin
      if (grant[0]) begin
        vld_p1[0]  <= 1'b1;
        data_p1[0] <= bus.sh_out;
      end else if (bus.resp0_ready) begin
        vld_p1[0] <= 1'b0;
      end
      if (grant[1]) begin
        vld_p1[1]  <= 1'b1;
        data_p1[1] <= bus.sh_out;
      end else if (bus.resp1_ready) begin
        vld_p1[1] <= 1'b0;
      end
    end
  end

  assign bus.resp0_valid = vld_p1[0];
  assign bus.resp1_valid = vld_p1[1];
  assign bus.resp0_data  = data_p1[0];
  assign bus.resp1_data  = data_p1[1];

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: vector table, directed multi-cycle sequences, result scoreboard.
module tb_shift_arbiter;
  import shift_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_arbiter_if #(.DATA_W(DW), .SHAMT_W(SW)) bus ();

  shift_arbiter #(.DATA_W(DW), .SHAMT_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Stand-in for the external shared shifter.
  always_comb begin
    case (bus.sh_fun)
      SH_SLL:  bus.sh_out = bus.sh_b << bus.sh_a;
      SH_SRL:  bus.sh_out = bus.sh_b >> bus.sh_a;
      SH_PASS: bus.sh_out = bus.sh_b;
      default: bus.sh_out = $unsigned($signed(bus.sh_b) >>> bus.sh_a);
    endcase
  end

  typedef struct {
    int          port;
    logic [1:0]  fun;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [7];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] fun, input logic [31:0] d,
                                        input logic [4:0] s);
    case (fun)
      SH_SLL:  return d << s;
      SH_SRL:  return d >> s;
      SH_PASS: return d;
      default: return $unsigned($signed(d) >>> s);
    endcase
  endfunction

  // Pops on consumption are compared before this cycle's acceptances are pushed.
  task automatic sb_update();
    logic [31:0] e;
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (bus.resp0_valid && bus.resp0_ready) begin
        if (q0.size() == 0) check("sb0_empty", bus.resp0_data, 32'hxxxx_xxxx);
        else begin e = q0.pop_front(); check("sb0", bus.resp0_data, e); end
      end
      if (bus.resp1_valid && bus.resp1_ready) begin
        if (q1.size() == 0) check("sb1_empty", bus.resp1_data, 32'hxxxx_xxxx);
        else begin e = q1.pop_front(); check("sb1", bus.resp1_data, e); end
      end
      if (bus.req0_valid && bus.req0_ready)
        q0.push_back(model(bus.req0_fun, bus.req0_data, bus.req0_shamt));
      if (bus.req1_valid && bus.req1_ready)
        q1.push_back(model(bus.req1_fun, bus.req1_data, bus.req1_shamt));
    end
  endtask

  task automatic settle();
    @(negedge clk);
    sb_update();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [1:0] f,
                         input logic [31:0] d, input logic [4:0] s);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_fun = f; bus.req0_data = d; bus.req0_shamt = s;
    end else begin
      bus.req1_valid = v; bus.req1_fun = f; bus.req1_data = d; bus.req1_shamt = s;
    end
  endtask

  task automatic set_rr(input int p, input logic r);
    if (p == 0) bus.resp0_ready = r;
    else        bus.resp1_ready = r;
  endtask

  function automatic logic [31:0] rdy(input int p);
    return 32'(p == 0 ? bus.req0_ready : bus.req1_ready);
  endfunction

  function automatic logic [31:0] rvld(input int p);
    return 32'(p == 0 ? bus.resp0_valid : bus.resp1_valid);
  endfunction

  function automatic logic [31:0] rdat(input int p);
    return p == 0 ? bus.resp0_data : bus.resp1_data;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp0;
    tbl[0] = '{0, SH_SLL,  32'h0000_0001, 5'd4,  32'h0000_0010};
    tbl[1] = '{1, SH_PASS, 32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF};
    tbl[2] = '{0, SH_SRA,  32'h8000_0000, 5'd4,  32'hF800_0000};
    tbl[3] = '{1, SH_SRL,  32'h8000_0000, 5'd31, 32'h0000_0001};
    tbl[4] = '{0, SH_SRL,  32'hF000_000F, 5'd0,  32'hF000_000F};
    tbl[5] = '{1, SH_SRA,  32'h7000_0000, 5'd31, 32'h0000_0000};
    tbl[6] = '{1, SH_SLL,  32'hFFFF_FFFF, 5'd31, 32'h8000_0000};

    // Reset state, with requests pending to show grants are suppressed.
    reset = 1'b1;
    set_req(0, 1'b1, SH_SLL, 32'h1234_5678, 5'd3);
    set_req(1, 1'b1, SH_SRA, 32'h8765_4321, 5'd9);
    set_rr(0, 1'b0); set_rr(1, 1'b0);
    adv(); adv();
    settle();
    check("rst_resp0_valid", rvld(0), 32'd0);
    check("rst_resp1_valid", rvld(1), 32'd0);
    check("rst_resp0_data", rdat(0), 32'd0);
    check("rst_resp1_data", rdat(1), 32'd0);
    check("rst_req0_ready", rdy(0), 32'd0);
    check("rst_req1_ready", rdy(1), 32'd0);
    check("rst_sh_a", bus.sh_a, 32'd0);
    check("rst_sh_b", bus.sh_b, 32'd0);
    check("rst_sh_fun", 32'(bus.sh_fun), 32'd0);
    adv();
    reset = 1'b0;
    set_req(0, 1'b0, SH_SLL, 32'd0, 5'd0);
    set_req(1, 1'b0, SH_SLL, 32'd0, 5'd0);

    // Single-port vectors: grant, shifter mux, 1-cycle latency, drain.
    for (int i = 0; i < 7; i++) begin
      set_req(tbl[i].port, 1'b1, tbl[i].fun, tbl[i].data, tbl[i].shamt);
      settle();
      check("vec_ready", rdy(tbl[i].port), 32'd1);
      check("vec_other_ready", rdy(1 - tbl[i].port), 32'd0);
      check("vec_sh_fun", 32'(bus.sh_fun), 32'(tbl[i].fun));
      check("vec_sh_b", bus.sh_b, tbl[i].data);
      check("vec_sh_a", bus.sh_a, 32'(tbl[i].shamt));
      adv();
      set_req(tbl[i].port, 1'b0, SH_SLL, 32'd0, 5'd0);
      settle();
      check("vec_resp_valid", rvld(tbl[i].port), 32'd1);
      check("vec_resp_data", rdat(tbl[i].port), tbl[i].exp);
      adv();
      set_rr(tbl[i].port, 1'b1);
      settle();
      adv();
      set_rr(tbl[i].port, 1'b0);
      settle();
      check("vec_resp_drained", rvld(tbl[i].port), 32'd0);
      adv();
    end

    // Contention right after reset: port 0 first, then port 1.
    reset = 1'b1;
    settle();
    adv();
    reset = 1'b0;
    set_req(0, 1'b1, SH_SRL, 32'h8000_0000, 5'd31);
    set_req(1, 1'b1, SH_SLL, 32'h0000_0001, 5'd31);
    settle();
    check("cont_c1_ready0", rdy(0), 32'd1);
    check("cont_c1_ready1", rdy(1), 32'd0);
    adv();
    set_req(0, 1'b0, SH_SLL, 32'd0, 5'd0);
    settle();
    check("cont_c2_ready1", rdy(1), 32'd1);
    check("cont_resp0_valid", rvld(0), 32'd1);
    check("cont_resp0_data", rdat(0), 32'h0000_0001);
    adv();
    set_req(1, 1'b0, SH_SLL, 32'd0, 5'd0);
    settle();
    check("cont_resp1_valid", rvld(1), 32'd1);
    check("cont_resp1_data", rdat(1), 32'h8000_0000);
    adv();
    set_rr(0, 1'b1); set_rr(1, 1'b1);
    settle();
    adv();

    // Sustained contention with both consumers always ready.
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1'b1, SH_SLL, 32'(i + 1), 5'd1);
      set_req(1, 1'b1, SH_SRL, 32'(i + 100), 5'd1);
      settle();
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      exp0 = 1'b1;
`else
      exp0 = (i % 2) == 0;
`endif
      check("sust_ready0", rdy(0), 32'(exp0));
      check("sust_ready1", rdy(1), 32'(!exp0));
      adv();
    end
    set_req(0, 1'b0, SH_SLL, 32'd0, 5'd0);
    set_req(1, 1'b0, SH_SLL, 32'd0, 5'd0);
    settle();
    adv();
    set_rr(0, 1'b0); set_rr(1, 1'b0);

    // Backpressure on port 1 while port 0 keeps being served.
    set_req(1, 1'b1, SH_PASS, 32'h1111_1111, 5'd0);
    settle();
    check("bp_first_ready1", rdy(1), 32'd1);
    adv();
    set_req(1, 1'b1, SH_PASS, 32'h2222_2222, 5'd3);
    set_req(0, 1'b1, SH_SLL, 32'h0000_0003, 5'd2);
    settle();
    check("bp_ready1_blocked", rdy(1), 32'd0);
    check("bp_ready0_served", rdy(0), 32'd1);
    check("bp_resp1_valid", rvld(1), 32'd1);
    adv();
    set_req(0, 1'b0, SH_SLL, 32'd0, 5'd0);
    settle();
    check("bp_resp1_held", rdat(1), 32'h1111_1111);
    check("bp_resp0_valid", rvld(0), 32'd1);
    check("bp_resp0_data", rdat(0), 32'h0000_000C);
    check("bp_ready1_still", rdy(1), 32'd0);
    adv();
    set_rr(0, 1'b1);
    settle();
    check("bp_ready1_wait", rdy(1), 32'd0);
    adv();
    set_rr(0, 1'b0);
    set_rr(1, 1'b1);
    settle();
    check("bp_ready1_release", rdy(1), 32'd1);
    adv();
    set_req(1, 1'b0, SH_SLL, 32'd0, 5'd0);
    settle();
    check("bp_resp1_new_valid", rvld(1), 32'd1);
    check("bp_resp1_new_data", rdat(1), 32'h2222_2222);
    adv();
    set_rr(1, 1'b0);
    settle();
    check("bp_resp1_drained", rvld(1), 32'd0);
    adv();

    // Reset while a result is held, with a request pending in the reset cycle.
    set_req(0, 1'b1, SH_SLL, 32'h0000_0001, 5'd2);
    settle();
    check("rmid_ready0", rdy(0), 32'd1);
    adv();
    set_req(0, 1'b0, SH_SLL, 32'd0, 5'd0);
    set_req(1, 1'b1, SH_PASS, 32'h5555_5555, 5'd0);
    reset = 1'b1;
    settle();
    check("rmid_held_before", rvld(0), 32'd1);
    check("rmid_ready1_in_reset", rdy(1), 32'd0);
    adv();
    reset = 1'b0;
    set_req(1, 1'b0, SH_SLL, 32'd0, 5'd0);
    settle();
    check("rmid_resp0_valid", rvld(0), 32'd0);
    check("rmid_resp0_data", rdat(0), 32'd0);
    check("rmid_resp1_lost", rvld(1), 32'd0);
    adv();
    set_req(0, 1'b1, SH_PASS, 32'hA5A5_A5A5, 5'd0);
    set_req(1, 1'b1, SH_PASS, 32'h5A5A_5A5A, 5'd0);
    settle();
    check("rmid_last_ready0", rdy(0), 32'd1);
    check("rmid_last_ready1", rdy(1), 32'd0);
    adv();
    set_req(0, 1'b0, SH_SLL, 32'd0, 5'd0);
    set_req(1, 1'b0, SH_SLL, 32'd0, 5'd0);
    set_rr(0, 1'b1); set_rr(1, 1'b1);
    settle();
    adv();
    settle();
    adv();

    check("sb0_left", 32'(q0.size()), 32'd0);
    check("sb1_left", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning shifter operand/result width.
REQ-002 The block SHALL have parameter SHAMT_W, default 5, meaning shift-amount width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-006 reqN_ready  output  1  requester N operation accepted this cycle when high with reqN_valid.
REQ-007 reqN_fun  input  2  op code: 00 SLL, 01 SRL, 10 pass data, 11 SRA.
REQ-008 reqN_shamt  input  SHAMT_W  shift amount.
REQ-009 reqN_data  input  DATA_W  value to shift.
REQ-010 respN_valid  output  1  result for requester N held in its result register.
REQ-011 respN_ready  input  1  requester N consumes result.
REQ-012 respN_data  output  DATA_W  result for requester N.
REQ-013 sh_a  output  DATA_W  to shared shifter shift-amount input; shamt zero-extended.
REQ-014 sh_b  output  DATA_W  to shared shifter data input.
REQ-015 sh_fun  output  2  to shared shifter function select.
REQ-016 sh_out  input  DATA_W  combinational result from shared shifter.

Function
REQ-017 The block SHALL drive one grant per cycle to the shared shifter; sh_a/sh_b/sh_fun SHALL mux the granted requester's fields, else all zero.
REQ-018 Requester N SHALL be eligible when reqN_valid=1 and its result slot is free: respN_valid=0, or respN_valid=1 and respN_ready=1 in the same cycle.
REQ-019 reqN_ready SHALL be high only for the granted requester, combinationally in the cycle of grant.
REQ-020 On acceptance, sh_out SHALL be registered into respN_data and respN_valid set at the next edge; latency exactly 1 cycle.
REQ-021 respN_valid SHALL stay high with respN_data stable until the cycle respN_ready=1; simultaneous drain and new accept SHALL leave respN_valid=1 with new data.
REQ-022 Arbitration SHALL be round-robin via a 1-bit pointer state LAST (0 or 1): if both eligible, grant the port not equal to LAST; if one eligible, grant it.
REQ-023 LAST SHALL update to the granted port only on an accepted transfer; unchanged in idle cycles.
REQ-024 A request held valid while not granted SHALL have its fields ignored; no partial acceptance.
REQ-025 sh_a SHALL carry reqN_shamt in bits [SHAMT_W-1:0], upper bits zero.
REQ-026 respN_ready while respN_valid=0 SHALL have no effect.

Reset
REQ-027 On reset: respN_valid=0, respN_data=0, LAST=1 (port 0 wins first contention), reqN_ready=0, sh_* =0.
REQ-028 Reset mid-operation SHALL discard any held result with no response issued; the accepting cycle's transfer is lost.

Configuration
REQ-029 Macro SHIFT_ARB_FIXED_PRIO_EN: when defined, port 0 SHALL always win contention and LAST SHALL be removed; when undefined, round-robin per REQ-022/023.

Structure
REQ-030 Shared package SHALL hold op-code constants (SH_SLL=2'b00, SH_SRL=2'b01, SH_PASS=2'b10, SH_SRA=2'b11) and the default widths.
REQ-031 Grant logic SHALL be a sub-module shift_arb_rr (inputs: two eligibility bits, LAST; output: one-hot grant); the shared shifter instance stays outside this block.

Verification
REQ-032 Single port: req0 SLL, data=0x0000_0001, shamt=4 -> req0_ready same cycle, resp0_valid next cycle, resp0_data=0x0000_0010.
REQ-033 Contention after reset: both valid (req0 SRL 0x8000_0000 shamt 31; req1 SLL 0x1 shamt 31) -> cycle 1 grants port 0, cycle 2 grants port 1; resp0=0x0000_0001, resp1=0x8000_0000.
REQ-034 Sustained contention, both resp_ready=1 -> grants alternate 0,1,0,1 for 8 cycles; with SHIFT_ARB_FIXED_PRIO_EN -> port 0 granted all 8.
REQ-035 Backpressure: resp1_ready=0, resp1_valid=1, req1 valid -> req1_ready=0, port 0 still served; resp1_data unchanged until resp1_ready=1, then req1 accepted same cycle.
REQ-036 Pass op: req1 fun=10, data=0xDEAD_BEEF, shamt=7 -> resp1_data=0xDEAD_BEEF.
REQ-037 Reset asserted while resp0_valid=1 -> next cycle resp0_valid=0, resp0_data=0, LAST=1.
